// File: rtl/mem_lsu_stage.sv
// Memory/writeback load-store unit: dcache request, lane alignment, load extend.
// Define LSU_PERF_CNT_EN to build the load/store/stall performance counters.
module mem_lsu_stage #(
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              ex_load,
    input  logic              ex_store,
    input  logic [2:0]        ex_funct3,
    input  logic [31:0]       ex_addr,
    input  logic [31:0]       ex_store_data,
    input  logic [4:0]        ex_rd,
    input  logic              ex_reg_we,
    output logic [31:0]       dcache_addr,
    output logic              dcache_re,
    output logic [3:0]        dcache_we,
    output logic [31:0]       dcache_din,
    input  logic [31:0]       dcache_dout,
    input  logic              stall,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              misalign_err,
    output logic [PERF_W-1:0] perf_loads,
    output logic [PERF_W-1:0] perf_stores,
    output logic [PERF_W-1:0] perf_stall_cycles
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic [2:0]  funct3_q;
    logic [4:0]  rd_q;
    logic        load_q;

    logic        accept, is_mem, legal, f3_ok, aligned;
    logic        resp_done;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_data;

    assign ex_ready  = (state == IDLE);
    assign accept    = ex_valid && ex_ready;
    assign is_mem    = ex_load || ex_store;
    assign resp_done = (state == RESP) && !stall;

    always_comb begin
        f3_ok = 1'b0;
        if (ex_load && ex_store)
            f3_ok = 1'b0;
        else if (ex_store)
            f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010,
                                      3'b100, 3'b101};
    end

    assign aligned = !((ex_funct3[1:0] == 2'b01 && ex_addr[0]) ||
                       (ex_funct3[1:0] == 2'b10 && ex_addr[1:0] != 2'b00));
    assign legal   = f3_ok && aligned;

    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept && is_mem && legal) state_nxt = REQ;
            REQ:  if (!stall) state_nxt = load_q ? RESP : IDLE;
            RESP: if (!stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // dcache outputs derive only from state and latched fields, so they hold under stall
    always_comb begin
        dcache_addr = '0;
        dcache_re   = 1'b0;
        dcache_we   = 4'b0000;
        dcache_din  = '0;
        if (state != IDLE)
            dcache_addr = {addr_q[31:2], 2'b00};
        if (state == REQ) begin
            if (load_q) begin
                dcache_re = 1'b1;
            end else begin
                unique case (funct3_q[1:0])
                    2'b00: begin
                        dcache_we  = 4'b0001 << addr_q[1:0];
                        dcache_din = {4{data_q[7:0]}};
                    end
                    2'b01: begin
                        dcache_we  = addr_q[1] ? 4'b1100 : 4'b0011;
                        dcache_din = {2{data_q[15:0]}};
                    end
                    default: begin
                        dcache_we  = 4'b1111;
                        dcache_din = data_q;
                    end
                endcase
            end
        end
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   byte_v = dcache_dout[7:0];
            2'b01:   byte_v = dcache_dout[15:8];
            2'b10:   byte_v = dcache_dout[23:16];
            default: byte_v = dcache_dout[31:24];
        endcase
        half_v = addr_q[1] ? dcache_dout[31:16] : dcache_dout[15:0];
        unique case (funct3_q)
            3'b000:  load_data = {{24{byte_v[7]}}, byte_v};
            3'b100:  load_data = {24'b0, byte_v};
            3'b001:  load_data = {{16{half_v[15]}}, half_v};
            3'b101:  load_data = {16'b0, half_v};
            default: load_data = dcache_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q   <= '0;
            data_q   <= '0;
            funct3_q <= '0;
            rd_q     <= '0;
            load_q   <= 1'b0;
        end else if (accept && is_mem) begin
            addr_q   <= ex_addr;
            data_q   <= ex_store_data;
            funct3_q <= ex_funct3;
            rd_q     <= ex_rd;
            load_q   <= ex_load;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
        end else begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            misalign_err <= 1'b0;
            if (accept && !is_mem) begin
                wb_valid <= 1'b1;
                wb_data  <= ex_addr;
                wb_rd    <= ex_rd;
                wb_we    <= ex_reg_we && (ex_rd != 5'd0);
            end else if (accept && !legal) begin
                misalign_err <= 1'b1;
            end else if (resp_done) begin
                wb_valid <= 1'b1;
                wb_data  <= load_data;
                wb_rd    <= rd_q;
                wb_we    <= (rd_q != 5'd0);
            end
        end
    end

`ifdef LSU_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_loads        <= '0;
            perf_stores       <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (resp_done)
                perf_loads <= perf_loads + PERF_ONE;
            if (state == REQ && !stall && !load_q)
                perf_stores <= perf_stores + PERF_ONE;
            if (state != IDLE && stall)
                perf_stall_cycles <= perf_stall_cycles + PERF_ONE;
        end
    end
`else
    assign perf_loads        = '0;
    assign perf_stores       = '0;
    assign perf_stall_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_lsu_stage.sv
// Directed bench for mem_lsu_stage: vector table plus stall and reset sequences.
// Perf counter checks follow LSU_PERF_CNT_EN.
module tb_mem_lsu_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid, ex_ready, ex_load, ex_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr, ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_we;
    logic [31:0] dcache_addr, dcache_din, dcache_dout;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic        stall;
    logic        wb_valid, wb_we, misalign_err;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] perf_loads, perf_stores, perf_stall_cycles;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_lsu_stage #(.PERF_W(32)) dut (
        .clk(clk), .reset(reset),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_load(ex_load), .ex_store(ex_store),
        .ex_funct3(ex_funct3), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_we(ex_reg_we),
        .dcache_addr(dcache_addr), .dcache_re(dcache_re),
        .dcache_we(dcache_we), .dcache_din(dcache_din),
        .dcache_dout(dcache_dout), .stall(stall),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
        .wb_data(wb_data), .misalign_err(misalign_err),
        .perf_loads(perf_loads), .perf_stores(perf_stores),
        .perf_stall_cycles(perf_stall_cycles)
    );

    typedef struct packed {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rwe;
        logic [31:0] dout;
        logic        err;
        logic [3:0]  we;
        logic [31:0] din;
        logic [31:0] wdata;
        logic        wwe;
    } vec_t;

    localparam int NV = 18;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic ld, input logic st, input logic [2:0] f3,
        input logic [31:0] addr, input logic [31:0] sdata,
        input logic [4:0] rd, input logic rwe, input logic [31:0] dout,
        input logic err, input logic [3:0] we, input logic [31:0] din,
        input logic [31:0] wdata, input logic wwe);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr;
        v.sdata = sdata; v.rd = rd; v.rwe = rwe; v.dout = dout;
        v.err = err; v.we = we; v.din = din;
        v.wdata = wdata; v.wwe = wwe;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
        ex_funct3 = 3'b000; ex_addr = '0; ex_store_data = '0;
        ex_rd = '0; ex_reg_we = 1'b0;
    endtask

    task automatic run_vec(input int i, input vec_t v);
        string t;
        t = $sformatf("v%0d", i);
        stall = 1'b0;
        dcache_dout = v.dout;
        chk({t, " ready"}, ex_ready, 1);
        ex_valid = 1'b1; ex_load = v.ld; ex_store = v.st;
        ex_funct3 = v.f3; ex_addr = v.addr;
        ex_store_data = v.sdata; ex_rd = v.rd; ex_reg_we = v.rwe;
        @(negedge clk);
        idle_inputs();
        if (v.err) begin
            chk({t, " err"}, misalign_err, 1);
            chk({t, " re"}, dcache_re, 0);
            chk({t, " we"}, dcache_we, 0);
            chk({t, " wbv"}, wb_valid, 0);
            chk({t, " ready1"}, ex_ready, 1);
            @(negedge clk);
            chk({t, " err_pulse"}, misalign_err, 0);
            chk({t, " wbv2"}, wb_valid, 0);
        end else if (!v.ld && !v.st) begin
            chk({t, " wbv"}, wb_valid, 1);
            chk({t, " wbdata"}, wb_data, v.wdata);
            chk({t, " wbwe"}, wb_we, v.wwe);
            chk({t, " wbrd"}, wb_rd, v.rd);
            chk({t, " err"}, misalign_err, 0);
            @(negedge clk);
            chk({t, " wbv_pulse"}, wb_valid, 0);
        end else begin
            chk({t, " err"}, misalign_err, 0);
            chk({t, " addr"}, dcache_addr, {v.addr[31:2], 2'b00});
            chk({t, " re"}, dcache_re, v.ld);
            chk({t, " we"}, dcache_we, v.we);
            if (v.st) chk({t, " din"}, dcache_din, v.din);
            @(negedge clk);
            if (v.st) begin
                chk({t, " ready2"}, ex_ready, 1);
                chk({t, " wbv2"}, wb_valid, 0);
                chk({t, " we2"}, dcache_we, 0);
            end else begin
                chk({t, " re2"}, dcache_re, 0);
                chk({t, " wbv2"}, wb_valid, 0);
                chk({t, " ready2"}, ex_ready, 0);
                @(negedge clk);
                chk({t, " wbv3"}, wb_valid, 1);
                chk({t, " wbdata"}, wb_data, v.wdata);
                chk({t, " wbwe"}, wb_we, v.wwe);
                chk({t, " wbrd"}, wb_rd, v.rd);
                @(negedge clk);
                chk({t, " wbv_pulse"}, wb_valid, 0);
            end
        end
    endtask

    logic stall_seq [7];
    logic re_seq    [7];
    logic [31:0] pl0, ps0;

    initial begin
        vecs[0]  = mk(1,0,3'b000,32'h0000_1003,0,1,1,32'h80AA_BBCC,0,0,0,32'hFFFF_FF80,1);
        vecs[1]  = mk(1,0,3'b100,32'h0000_1003,0,2,1,32'h80AA_BBCC,0,0,0,32'h0000_0080,1);
        vecs[2]  = mk(1,0,3'b001,32'h0000_1002,0,3,1,32'h80AA_BBCC,0,0,0,32'hFFFF_80AA,1);
        vecs[3]  = mk(1,0,3'b101,32'h0000_1000,0,4,1,32'h80AA_BBCC,0,0,0,32'h0000_BBCC,1);
        vecs[4]  = mk(1,0,3'b010,32'h0000_1004,0,0,1,32'h1234_5678,0,0,0,32'h1234_5678,0);
        vecs[5]  = mk(1,0,3'b000,32'h0000_1001,0,6,1,32'h80AA_BBCC,0,0,0,32'hFFFF_FFBB,1);
        vecs[6]  = mk(0,1,3'b001,32'h0000_2002,32'h1234_ABCD,0,0,0,0,4'b1100,32'hABCD_ABCD,0,0);
        vecs[7]  = mk(0,1,3'b000,32'h0000_3001,32'h0000_00A5,0,0,0,0,4'b0010,32'hA5A5_A5A5,0,0);
        vecs[8]  = mk(0,1,3'b010,32'h0000_4000,32'hCAFE_F00D,0,0,0,0,4'b1111,32'hCAFE_F00D,0,0);
        vecs[9]  = mk(0,1,3'b001,32'h0000_2000,32'h1234_ABCD,0,0,0,0,4'b0011,32'hABCD_ABCD,0,0);
        vecs[10] = mk(1,0,3'b010,32'h0000_0102,0,7,1,0,1,0,0,0,0);
        vecs[11] = mk(1,0,3'b001,32'h0000_0101,0,7,1,0,1,0,0,0,0);
        vecs[12] = mk(0,1,3'b100,32'h0000_0000,32'h5555_5555,0,0,0,1,0,0,0,0);
        vecs[13] = mk(1,1,3'b010,32'h0000_0000,0,7,1,0,1,0,0,0,0);
        vecs[14] = mk(1,0,3'b011,32'h0000_0000,0,7,1,0,1,0,0,0,0);
        vecs[15] = mk(0,0,3'b000,32'hDEAD_BEEF,0,0,1,0,0,0,0,32'hDEAD_BEEF,0);
        vecs[16] = mk(0,0,3'b000,32'hDEAD_BEEF,0,5,1,0,0,0,0,32'hDEAD_BEEF,1);
        vecs[17] = mk(0,0,3'b000,32'h0000_0042,0,5,0,0,0,0,0,32'h0000_0042,0);

        stall_seq = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        re_seq    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

        idle_inputs();
        stall = 1'b0;
        dcache_dout = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst wbv", wb_valid, 0);
        chk("rst wbwe", wb_we, 0);
        chk("rst wbdata", wb_data, 0);
        chk("rst wbrd", wb_rd, 0);
        chk("rst err", misalign_err, 0);
        chk("rst re", dcache_re, 0);
        chk("rst we", dcache_we, 0);
        chk("rst addr", dcache_addr, 0);
        chk("rst din", dcache_din, 0);
        chk("rst ready", ex_ready, 1);
        chk("rst perf_ld", perf_loads, 0);
        chk("rst perf_stall", perf_stall_cycles, 0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++)
            run_vec(i, vecs[i]);

        // LW held in REQ for 3 stalled cycles and RESP for 2
        pl0 = perf_loads;
        ps0 = perf_stall_cycles;
        dcache_dout = 32'h0BAD_F00D;
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0100; ex_rd = 5'd9;
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            stall = stall_seq[i];
            chk($sformatf("stl%0d addr", i), dcache_addr, 32'h0000_0100);
            chk($sformatf("stl%0d re", i), dcache_re, re_seq[i]);
            chk($sformatf("stl%0d we", i), dcache_we, 0);
            chk($sformatf("stl%0d wbv", i), wb_valid, 0);
            @(negedge clk);
        end
        stall = 1'b0;
        chk("stl wbv", wb_valid, 1);
        chk("stl wbdata", wb_data, 32'h0BAD_F00D);
        chk("stl wbrd", wb_rd, 9);
        @(negedge clk);
        chk("stl wbv_pulse", wb_valid, 0);
`ifdef LSU_PERF_CNT_EN
        chk("perf stall", perf_stall_cycles - ps0, 5);
        chk("perf loads", perf_loads - pl0, 1);
        chk("perf stores", perf_stores, 4);
`else
        chk("perf stall", perf_stall_cycles, 0);
        chk("perf loads", perf_loads, 0);
        chk("perf stores", perf_stores, 0);
`endif

        // reset while a load is in RESP drops the writeback
        ex_valid = 1'b1; ex_load = 1'b1; ex_funct3 = 3'b010;
        ex_addr = 32'h0000_0200; ex_rd = 5'd3;
        @(negedge clk);
        idle_inputs();
        chk("mid re_req", dcache_re, 1);
        @(negedge clk);
        chk("mid ready_resp", ex_ready, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("mid wbv", wb_valid, 0);
        chk("mid re", dcache_re, 0);
        chk("mid ready", ex_ready, 1);
        chk("mid wbdata", wb_data, 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post%0d wbv", i), wb_valid, 0);
            chk($sformatf("post%0d re", i), dcache_re, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_lsu_stage.md
Name: mem_lsu_stage

Overview:
- Load/store unit for the memory/writeback stage of the 3-stage Riscv151 core, directly downstream of the ALU stage.
- Accepts one request per cycle from the ALU stage and drives the dcache ports.
- Aligns store data and builds byte enables. Extracts, sign-extends or zero-extends load data.
- Produces the registered regfile writeback. Non-memory ALU results pass through to writeback.

Parameters:
- PERF_W, 32: width of the optional performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset (0 = reset)
- ex_valid  in  1  ALU stage presents a request
- ex_ready  out  1  stage can accept a request this cycle
- ex_load  in  1  request is a load
- ex_store  in  1  request is a store
- ex_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ex_addr  in  32  memory address, or ALU result for non-memory ops
- ex_store_data  in  32  rs2 data for stores
- ex_rd  in  5  destination register
- ex_reg_we  in  1  instruction writes rd
- dcache_addr  out  32  word address {addr[31:2],2'b00}
- dcache_re  out  1  read enable
- dcache_we  out  4  byte write enables
- dcache_din  out  32  store data, lane-aligned
- dcache_dout  in  32  read data, valid the cycle after an accepted read
- stall  in  1  memory not ready; hold all dcache outputs stable
- wb_valid  out  1  writeback valid (one-cycle pulse)
- wb_we  out  1  regfile write enable
- wb_rd  out  5  writeback register index
- wb_data  out  32  writeback data
- misalign_err  out  1  one-cycle pulse on a misaligned access or illegal funct3
- perf_loads  out  PERF_W  completed loads (optional)
- perf_stores  out  PERF_W  completed stores (optional)
- perf_stall_cycles  out  PERF_W  cycles spent in REQ/RESP with stall=1 (optional)

Behaviour:
- FSM has three states: IDLE, REQ, RESP.
- ex_ready = (state==IDLE). A request is accepted when ex_valid && ex_ready.
- Reset:
  - Takes effect at the rising edge with reset=0.
  - State goes to IDLE. wb_valid, wb_we, misalign_err, wb_rd and wb_data all go to 0.
  - dcache_re=0, dcache_we=4'b0000, dcache_addr=0, dcache_din=0. Perf counters clear.
  - Reset mid-operation abandons the request with no writeback.
- IDLE, non-memory request (ex_load=ex_store=0):
  - Next cycle: wb_valid=1, wb_data=ex_addr, wb_rd=ex_rd, wb_we=ex_reg_we && (ex_rd!=0). Stay in IDLE.
- IDLE, memory request:
  - Latch addr, funct3, store data and rd.
  - Check alignment:
    - H/HU/SH require addr[0]=0.
    - W requires addr[1:0]=00.
    - Stores allow only funct3 000/001/010. Loads allow 000/001/010/100/101.
  - On violation: misalign_err=1 next cycle, no dcache access, no writeback, stay in IDLE.
  - Otherwise go to REQ.
- If ex_load and ex_store are both 1: treat the request as illegal and pulse misalign_err.
- REQ:
  - dcache_addr = word address of the latched addr.
  - Load: dcache_re=1.
  - Store byte enables and data:
    - SB: dcache_we=4'b0001<<addr[1:0], dcache_din={4{data[7:0]}}.
    - SH: dcache_we = addr[1] ? 1100 : 0011, dcache_din={2{data[15:0]}}.
    - SW: dcache_we=1111, dcache_din=data.
  - stall=1: remain in REQ with outputs unchanged.
  - stall=0: a store returns to IDLE; a load goes to RESP.
- RESP:
  - dcache_re=0, dcache_we=0. Hold the address.
  - stall=1: remain in RESP.
  - stall=0: select the byte or half by the latched addr[1:0], extend per funct3, and register it into wb_data. Pulse wb_valid next cycle; wb_we=(rd!=0). Return to IDLE.
- Latency with stall=0 throughout, request accepted at cycle T:
  - Load: wb_valid at T+3.
  - Store: ex_ready high again at T+2.
  - Non-memory request: wb_valid at T+1.
- wb_valid is exactly one cycle wide per completed op. Stores never assert wb_valid.

Optional Feature:
- Macro: LSU_PERF_CNT_EN.
- Defined: the three PERF_W counters increment as described. They wrap modulo 2^PERF_W and clear on reset.
- Undefined: perf outputs are tied to 0 and no counter flops are built.

Test Plan:
- LB from addr 0x0000_1003, dout=0x80AA_BBCC, stall=0 -> dcache_addr=0x0000_1000, re=1 at T+1; wb_data=0xFFFF_FF80 with wb_valid at T+3. Same access as LBU -> wb_data=0x0000_0080.
- SH to 0x0000_2002, data 0x1234_ABCD -> dcache_we=1100, din=0xABCD_ABCD at T+1; no wb_valid; ex_ready=1 at T+2.
- LW to 0x0000_0100 with stall=1 for 3 cycles in REQ, then 2 cycles in RESP -> dcache outputs stable throughout; wb_valid exactly once; perf_stall_cycles=5 when LSU_PERF_CNT_EN is defined.
- LW to 0x0000_0102 -> misalign_err pulse at T+1; dcache_re/we stay 0; no wb_valid; ex_ready stays 1.
- Non-memory op, ex_addr=0xDEAD_BEEF, rd=0 -> wb_valid=1 at T+1, wb_we=0. Same op with rd=5 -> wb_we=1, wb_rd=5.
- reset=0 asserted while in RESP -> next cycle state IDLE, wb_valid=0, dcache_re=0; no writeback after reset releases.
